// File: rtl/vrms_meter_win.sv
// vrms_meter_win: windowed true-RMS meter -- square, 2^k-sample mean by shift, bit-serial sqrt.
// Define VRMS_DC_BLOCK_EN to remove the window mean and report it on v_dc (AC RMS on v_rms).
module vrms_meter_win #(
  parameter int DATA_W       = 12,
  parameter int WIN_LOG2_MIN = 5,
  parameter int WIN_LOG2_MAX = 12
) (
  input  logic              clk_fs,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_s,
  input  logic [3:0]        win_sel,
  input  logic              irq_clr,
  output logic [DATA_W-1:0] v_rms,
  output logic [DATA_W-1:0] v_dc,
  output logic              rms_valid,
  output logic              busy,
  output logic              irq
);
  localparam int SQ_W  = 2*DATA_W-1;
  localparam int ACC_W = SQ_W + WIN_LOG2_MAX;
  localparam int CNT_W = WIN_LOG2_MAX;
  localparam int R_W   = DATA_W + 4;
  localparam int BC_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic [3:0] clamp_k(input logic [3:0] sel);
    if (int'(sel) < WIN_LOG2_MIN) return 4'(WIN_LOG2_MIN);
    if (int'(sel) > WIN_LOG2_MAX) return 4'(WIN_LOG2_MAX);
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] win_mask(input logic [3:0] k);
    return ~({CNT_W{1'b1}} << k);
  endfunction

  // One non-restoring sqrt step: the remainder sign picks subtract (4q+1) or add (4q+3).
  function automatic logic signed [R_W-1:0] nr_step(input logic signed [R_W-1:0] rem,
                                                     input logic [DATA_W-1:0] root,
                                                     input logic [1:0] pair);
    logic signed [R_W-1:0] sh;
    logic signed [R_W-1:0] t;
    sh = (rem <<< 2) | R_W'(pair);
    if (rem[R_W-1]) begin
      t = R_W'({root, 2'b11});
      return sh + t;
    end
    t = R_W'({root, 2'b01});
    return sh - t;
  endfunction

  // Stage 1: square the sample, capture its window exponent
  logic signed [DATA_W-1:0]   x_s;
  logic signed [2*DATA_W-1:0] x_ext;
  logic        [2*DATA_W-1:0] sq_p1;
  logic        [3:0]          k_p1;
  logic                       vld_p1;

  assign x_s   = data_s;
  assign x_ext = x_s;

  always_ff @(posedge clk_fs) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= data_valid;
  end

  always_ff @(posedge clk_fs) begin
    if (data_valid) begin
      sq_p1 <= x_ext * x_ext;
      k_p1  <= clamp_k(win_sel);
    end
  end

  // Stage 2: accumulate, close the window on its last sample
  logic [ACC_W-1:0] acc_q, acc_sum;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       k_cur_q, k_use;
  logic             win_end;
  logic [SQ_W-1:0]  mean;

  assign k_use   = (cnt_q == '0) ? k_p1 : k_cur_q;
  assign acc_sum = acc_q + ACC_W'(sq_p1);
  assign win_end = vld_p1 && (cnt_q == win_mask(k_use));
  assign mean    = SQ_W'(acc_sum >> k_use);

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      k_cur_q <= 4'(WIN_LOG2_MIN);
    end else if (vld_p1) begin
      k_cur_q <= k_use;
      if (win_end) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_sum;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  logic                sqrt_go;
  logic [SQ_W-1:0]     sqrt_din;
  logic [DATA_W-1:0]   sqrt_dc;

`ifdef VRMS_DC_BLOCK_EN
  localparam int SX_W = DATA_W + WIN_LOG2_MAX;

  function automatic logic [SQ_W-1:0] sat_zero(input logic signed [2*DATA_W:0] v);
    if (v < 0) return '0;
    return SQ_W'(v);
  endfunction

  logic signed [DATA_W-1:0]   x_p1;
  logic signed [SX_W-1:0]     sx_q, sx_sum;
  logic signed [DATA_W-1:0]   dc_win, dc_p2;
  logic        [SQ_W-1:0]     mean_p2;
  logic                       vld_p2;
  logic signed [2*DATA_W-1:0] dc_ext;
  logic signed [2*DATA_W:0]   var_s;

  always_ff @(posedge clk_fs) begin
    if (data_valid) x_p1 <= x_s;
  end

  assign sx_sum = sx_q + SX_W'(x_p1);
  assign dc_win = DATA_W'(sx_sum >>> k_use);

  always_ff @(posedge clk_fs) begin
    if (rst)         sx_q <= '0;
    else if (vld_p1) sx_q <= win_end ? '0 : sx_sum;
  end

  // Stage 3: variance = mean of squares minus squared mean
  always_ff @(posedge clk_fs) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= win_end;
  end

  always_ff @(posedge clk_fs) begin
    if (win_end) begin
      mean_p2 <= mean;
      dc_p2   <= dc_win;
    end
  end

  assign dc_ext   = dc_p2;
  assign var_s    = $signed({2'b00, mean_p2}) - $signed({1'b0, dc_ext * dc_ext});
  assign sqrt_go  = vld_p2;
  assign sqrt_din = sat_zero(var_s);
  assign sqrt_dc  = dc_p2;
`else
  assign sqrt_go  = win_end;
  assign sqrt_din = mean;
  assign sqrt_dc  = '0;
`endif

  // Square-root FSM: one result bit per CALC cycle
  state_t                state_q, state_d;
  logic [BC_W-1:0]       bit_q;
  logic signed [R_W-1:0] rem_q, rem_nx;
  logic [DATA_W-1:0]     root_q, dc_run_q;
  logic [2*DATA_W-1:0]   rad_q;

  always_ff @(posedge clk_fs) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sqrt_go) state_d = CALC;
      CALC:    if (bit_q == BC_W'(DATA_W-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rem_nx = nr_step(rem_q, root_q, rad_q[2*DATA_W-1 -: 2]);

  always_ff @(posedge clk_fs) begin
    if (state_q == IDLE && sqrt_go) begin
      rad_q    <= {1'b0, sqrt_din};
      rem_q    <= '0;
      root_q   <= '0;
      bit_q    <= '0;
      dc_run_q <= sqrt_dc;
    end else if (state_q == CALC) begin
      rem_q  <= rem_nx;
      root_q <= {root_q[DATA_W-2:0], ~rem_nx[R_W-1]};
      rad_q  <= rad_q << 2;
      bit_q  <= bit_q + 1'b1;
    end
  end

  // Result registers and interrupt; a set in the pulse cycle beats irq_clr
  logic              rms_valid_q, irq_q;
  logic [DATA_W-1:0] v_rms_q, v_dc_q;

  always_ff @(posedge clk_fs) begin
    if (rst) begin
      rms_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      v_rms_q     <= '0;
      v_dc_q      <= '0;
    end else begin
      rms_valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        v_rms_q <= root_q;
        v_dc_q  <= dc_run_q;
      end
      if (rms_valid_q)  irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  assign v_rms     = v_rms_q;
  assign v_dc      = v_dc_q;
  assign rms_valid = rms_valid_q;
  assign busy      = (state_q != IDLE);
  assign irq       = irq_q | rms_valid_q;
endmodule

// File: tb/tb_vrms_meter_win.sv
// tb_vrms_meter_win: directed and randomized checks of vrms_meter_win against an arithmetic model.
module tb_vrms_meter_win;
  localparam int DATA_W = 12;
  localparam int WMIN   = 5;
  localparam int WMAX   = 12;
  localparam int LAT    = DATA_W + 3;

  logic              clk_fs = 1'b0;
  logic              rst, data_valid, irq_clr;
  logic [DATA_W-1:0] data_s;
  logic [3:0]        win_sel;
  logic [DATA_W-1:0] v_rms, v_dc;
  logic              rms_valid, busy, irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  longint m_sum;
  int     m_cnt, m_k;
  int     exp_rms[$], exp_cyc[$];
  int     got_rms[$], got_dc[$], got_cyc[$];

  vrms_meter_win #(.DATA_W(DATA_W), .WIN_LOG2_MIN(WMIN), .WIN_LOG2_MAX(WMAX)) dut (
    .clk_fs(clk_fs), .rst(rst), .data_valid(data_valid), .data_s(data_s),
    .win_sel(win_sel), .irq_clr(irq_clr), .v_rms(v_rms), .v_dc(v_dc),
    .rms_valid(rms_valid), .busy(busy), .irq(irq)
  );

  always #5 clk_fs = ~clk_fs;
  always @(posedge clk_fs) cyc <= cyc + 1;

  always @(negedge clk_fs) begin
    if (rms_valid === 1'b1) begin
      got_rms.push_back(int'(v_rms));
      got_dc.push_back(int'(v_dc));
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clampk(input logic [3:0] s);
    if (int'(s) < WMIN) return WMIN;
    if (int'(s) > WMAX) return WMAX;
    return int'(s);
  endfunction

  function automatic int isqrt(input longint n);
    longint r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return int'(r);
  endfunction

  task automatic tick();
    @(posedge clk_fs);
    #1;
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
    exp_rms.delete();
    exp_cyc.delete();
  endtask

  // Present one input cycle; a valid sample also advances the model window.
  task automatic drive(input bit v, input int x);
    data_valid = v;
    data_s     = x[DATA_W-1:0];
    if (v) begin
      if (m_cnt == 0) m_k = clampk(win_sel);
      m_sum += longint'(x) * longint'(x);
      m_cnt++;
      if (m_cnt == (1 << m_k)) begin
        exp_rms.push_back(isqrt(m_sum >> m_k));
        exp_cyc.push_back(cyc + LAT);
        m_sum = 0;
        m_cnt = 0;
      end
    end
    tick();
    data_valid = 1'b0;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic wait_results(input string tag);
    int n = 0;
    while (got_rms.size() < exp_rms.size() && n < 6000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, "_count"}, 64'(got_rms.size()), 64'(exp_rms.size()));
    while (exp_rms.size() > 0 && got_rms.size() > 0) begin
      check({tag, "_rms"}, 64'(got_rms.pop_front()), 64'(exp_rms.pop_front()));
      check({tag, "_lat"}, 64'(got_cyc.pop_front()), 64'(exp_cyc.pop_front()));
      check({tag, "_vdc"}, 64'(got_dc.pop_front()), 64'd0);
    end
    exp_rms.delete(); exp_cyc.delete();
    got_rms.delete(); got_dc.delete(); got_cyc.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; data_valid = 1'b0; data_s = '0; win_sel = 4'd5; irq_clr = 1'b0;
    m_sum = 0; m_cnt = 0; m_k = WMIN;
    repeat (3) tick();
    check("rst_v_rms", 64'(v_rms), 64'd0);
    check("rst_v_dc", 64'(v_dc), 64'd0);
    check("rst_rms_valid", 64'(rms_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    tick();

    // constant 100, window 32
    win_sel = 4'd5;
    for (int i = 0; i < 32; i++) drive(1'b1, 100);
    tick();
    check("t1_busy", 64'(busy), 64'd1);
    wait_results("t1");
    check("t1_irq", 64'(irq), 64'd1);
    check("t1_hold", 64'(v_rms), 64'd100);
    check("t1_busy_idle", 64'(busy), 64'd0);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("t1_irq_clr", 64'(irq), 64'd0);

    // alternating +/-1000
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1000);
      drive(1'b1, -1000);
    end
    wait_results("t2");

    // full-scale negative over the largest window
    win_sel = 4'd12;
    for (int i = 0; i < 4096; i++) drive(1'b1, -2048);
    wait_results("t3");
    check("t3_full_scale", 64'(v_rms), 64'd2048);

    // 50% valid duty: gaps do not change the result
    win_sel = 4'd5;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 100);
      drive(1'b0, 7);
    end
    wait_results("t4");

    // win_sel change mid-window applies only to the next window
    for (int i = 0; i < 96; i++) begin
      if (i == 10) win_sel = 4'd6;
      drive(1'b1, rnd_sample());
    end
    wait_results("t5");

    // random data, random gaps, win_sel churn including values below the minimum
    for (int i = 0; i < 400; i++) begin
      win_sel = 4'($urandom_range(0, 6));
      drive(($urandom_range(0, 3) != 0), rnd_sample());
    end
    while (m_cnt != 0) drive(1'b1, rnd_sample());
    wait_results("t6");

    // reset mid-window discards the partial sum
    win_sel = 4'd5;
    for (int i = 0; i < 10; i++) drive(1'b1, 2000);
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) drive(1'b1, 300);
    wait_results("t7");

    // reset during CALC: no result, outputs cleared
    for (int i = 0; i < 32; i++) drive(1'b1, 500);
    repeat (4) tick();
    check("t8_busy_calc", 64'(busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    check("t8_busy", 64'(busy), 64'd0);
    check("t8_v_rms", 64'(v_rms), 64'd0);
    check("t8_irq", 64'(irq), 64'd0);
    repeat (25) tick();
    check("t8_no_result", 64'(got_rms.size()), 64'd0);

    // irq_clr in the rms_valid cycle: set wins
    for (int i = 0; i < 32; i++) drive(1'b1, 700);
    n = 0;
    while (cyc < exp_cyc[0] && n < 100) begin
      tick();
      n++;
    end
    check("t9_pulse", 64'(rms_valid), 64'd1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("t9_set_wins", 64'(irq), 64'd1);
    check("t9_one_cycle", 64'(rms_valid), 64'd0);
    wait_results("t9");
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check("t9_irq_clr", 64'(irq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
